// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   localparam logic [1:0] MUX_START = 2'b00;
   localparam logic [1:0] MUX_DATA  = 2'b01;
   localparam logic [1:0] MUX_PAR   = 2'b10;
   localparam logic [1:0] MUX_STOP  = 2'b11;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit index counter: synchronous clear has priority over enable,
// terminal-count flag marks the last data bit.
module uart_tx_bit_cnt #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic          clk_i,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i) cnt_q <= cnt_d;

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, WIDTH data bits LSB first, optional
// parity, stop; one bit per clock, back-to-back frames accepted in STOP.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       Data_Valid,
   input  logic                       PAR_EN,
   output logic                       ser_load,
   output logic                       ser_en,
   output logic [$clog2(WIDTH)-1:0]   ser_idx,
   output logic [1:0]                 mux_sel,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int CW = $clog2(WIDTH);

   state_e          state_q;
   logic            par_en_q;
   logic [CW-1:0]   cnt;
   logic            cnt_tc;
   logic            in_data;

   assign in_data  = (state_q == S_DATA);
   assign ser_load = Data_Valid && RST && (state_q == S_IDLE || state_q == S_STOP);

   // Counter is zeroed on reset, on accept and when leaving DATA, so it
   // always reads 0 outside the DATA state.
   uart_tx_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
      .clk_i (CLK),
      .clr_i (!RST || ser_load || (in_data && cnt_tc)),
      .en_i  (in_data),
      .cnt_o (cnt),
      .tc_o  (cnt_tc)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         par_en_q <= 1'b0;
      end else begin
         if (ser_load) par_en_q <= PAR_EN;
         case (state_q)
            S_IDLE:   if (ser_load) state_q <= S_START;
            S_START:  state_q <= S_DATA;
            S_DATA:   if (cnt_tc) state_q <= par_en_q ? S_PARITY : S_STOP;
            S_PARITY: state_q <= S_STOP;
            S_STOP:   state_q <= ser_load ? S_START : S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mux_sel    = MUX_STOP;
      ser_en     = 1'b0;
      ser_idx    = '0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         S_START: begin
            mux_sel = MUX_START;
            busy    = 1'b1;
         end
         S_DATA: begin
            mux_sel = MUX_DATA;
            ser_en  = 1'b1;
            ser_idx = cnt;
            busy    = 1'b1;
         end
         S_PARITY: begin
            mux_sel = MUX_PAR;
            busy    = 1'b1;
         end
         S_STOP: begin
            busy       = 1'b1;
            frame_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed + randomized bench for uart_tx_ctrl against a per-cycle
// expected-output queue built from the frame format.
module tb_uart_tx_ctrl;

   localparam int WIDTH = 8;

   logic       clk = 1'b0;
   logic       rst, dv, pe;
   logic       ser_load, ser_en, busy, frame_done;
   logic [2:0] ser_idx;
   logic [1:0] mux_sel;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] mux;
      logic       en;
      logic [2:0] idx;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t q[$];
   int   last_done = -1;
   int   cyc = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
      .CLK        (clk),
      .RST        (rst),
      .Data_Valid (dv),
      .PAR_EN     (pe),
      .ser_load   (ser_load),
      .ser_en     (ser_en),
      .ser_idx    (ser_idx),
      .mux_sel    (mux_sel),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // A frame is the cycle-by-cycle line picture: start, data bits, parity, stop.
   task automatic push_frame(input bit par);
      q.push_back('{2'b00, 1'b0, 3'd0, 1'b1, 1'b0});
      for (int i = 0; i < WIDTH; i++) q.push_back('{2'b01, 1'b1, 3'(i), 1'b1, 1'b0});
      if (par) q.push_back('{2'b10, 1'b0, 3'd0, 1'b1, 1'b0});
      q.push_back('{2'b11, 1'b0, 3'd0, 1'b1, 1'b1});
   endtask

   task automatic step(input logic d, input logic p, input logic r, input bit do_chk = 1);
      exp_t e;
      logic exp_load;
      @(negedge clk);
      dv = d; pe = p; rst = r;
      #1;
      e        = (q.size() != 0) ? q[0] : '{2'b11, 1'b0, 3'd0, 1'b0, 1'b0};
      exp_load = d && r && (q.size() == 0 || q[0].done);
      if (do_chk) begin
         chk("ser_load",   8'(ser_load),   8'(exp_load));
         chk("mux_sel",    8'(mux_sel),    8'(e.mux));
         chk("ser_en",     8'(ser_en),     8'(e.en));
         chk("ser_idx",    8'(ser_idx),    8'(e.idx));
         chk("busy",       8'(busy),       8'(e.busy));
         chk("frame_done", 8'(frame_done), 8'(e.done));
      end
      if (do_chk && frame_done === 1'b1 && e.done) begin
         if (last_done >= 0 && cyc - last_done < 10)
            chk("done_gap_min", 8'(cyc - last_done >= 10), 8'd1);
         last_done = cyc;
      end
      @(posedge clk);
      cyc++;
      if (!r) begin
         q.delete();
      end else begin
         if (q.size() != 0) void'(q.pop_front());
         if (exp_load) push_frame(p);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int gap_a;
      dv = 1'b0; pe = 1'b0; rst = 1'b0;

      // reset held with strobe high; first cycle precedes any edge
      step(1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      idle(2);

      // frame without parity
      step(1'b1, 1'b0, 1'b1);
      idle(12);

      // frame with parity; PAR_EN dropped after accept
      step(1'b1, 1'b1, 1'b1);
      idle(12);

      // back-to-back: strobe during STOP, plus ignored strobe in DATA cycle 3
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);               // START
      for (int i = 0; i < WIDTH; i++)
         step(i == 3, 1'b1, 1'b1);          // DATA 0..7
      gap_a = cyc;
      step(1'b1, 1'b0, 1'b1);               // STOP, second accept
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1);
      chk("b2b_spacing", 8'(last_done - gap_a), 8'd0);
      step(1'b0, 1'b0, 1'b1);               // second STOP
      chk("b2b_gap", 8'(last_done - gap_a), 8'd10);
      idle(3);

      // abort at DATA cycle 5, then a clean frame
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 1'b0, 1'b1);
      idle(12);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         step(($urandom % 4) == 0, 1'($urandom), ($urandom % 60) != 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a byte-valid strobe and steps the TX datapath through start bit, WIDTH data bits (LSB first), optional parity bit and stop bit, one bit per CLK cycle.
- Drives the serializer load/shift enables, the TX output-mux select and the load strobe shared with the parity calculator.
- Sits between the UART register interface and the serializer, parity calculator and line mux.

Parameters:
- WIDTH, 8, data bits per frame; bit counter width is $clog2(WIDTH).

Ports:
- CLK  input  1  system clock, all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-low: sampled only on the CLK rising edge.
- Data_Valid  input  1  new byte available on the datapath P_DATA bus this cycle.
- PAR_EN  input  1  parity enable; sampled only when a frame is accepted.
- ser_load  output  1  accept strobe; loads the serializer and the parity calculator's data register.
- ser_en  output  1  serializer shift enable; high during every DATA cycle.
- ser_idx  output  $clog2(WIDTH)  index of the data bit currently on the line.
- mux_sel  output  2  line mux select: 00 start(0), 01 serial data, 10 parity bit, 11 stop/idle(1).
- busy  output  1  frame in progress.
- frame_done  output  1  single-cycle pulse in the STOP cycle.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP; binary-encoded state register.
- Reset: when RST=0 at a rising edge, the next state is IDLE and the bit counter and par_en_q clear. Reset values: ser_en=0, ser_idx=0, mux_sel=11, busy=0, frame_done=0.
- ser_load is combinational: ser_load = Data_Valid && (state==IDLE || state==STOP) && RST.
- Outputs other than ser_load are decoded from state and counter registers (Moore).
- Accept: on an edge with ser_load=1, par_en_q<=PAR_EN, counter<=0, next state START.
- IDLE: mux_sel=11, busy=0. Stays in IDLE while Data_Valid=0.
- START: exactly 1 cycle; mux_sel=00, busy=1; next state DATA.
- DATA: exactly WIDTH cycles; mux_sel=01, ser_en=1, ser_idx=counter.
  - Counter increments 0..WIDTH-1 each cycle.
  - When counter==WIDTH-1: counter<=0; next state PARITY if par_en_q=1, else STOP.
  - The counter never wraps within DATA.
- PARITY: 1 cycle; mux_sel=10; next state STOP.
- STOP: 1 cycle; mux_sel=11, frame_done=1, busy=1.
  - Data_Valid=1: ser_load=1 and next state START (back-to-back frame, no idle gap).
  - Data_Valid=0: next state IDLE.
- Data_Valid asserted in START, DATA or PARITY is ignored: no ser_load, no state change. Upstream holds the strobe until accepted.
- PAR_EN changes mid-frame have no effect; only par_en_q is used.
- Frame length, accept edge to return to IDLE: 1 + WIDTH + par_en_q + 1 cycles (10 or 11 for WIDTH=8).
- Reset mid-frame aborts immediately: the line returns to idle-high on the next cycle. No partial frame completion and no frame_done pulse.
- Simultaneous RST=0 and Data_Valid=1: reset wins, ser_load=0.
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package uart_pkg:
  - state enum for IDLE/START/DATA/PARITY/STOP.
  - mux_sel constants MUX_START=2'b00, MUX_DATA=2'b01, MUX_PAR=2'b10, MUX_STOP=2'b11.
- Optional sub-module uart_tx_bit_cnt: a $clog2(WIDTH) counter with clear, enable and terminal-count flag.
- FSM next-state logic and output decode stay in uart_tx_ctrl.

Test Plan:
- Reset: hold RST=0 for 3 cycles with Data_Valid=1 -> ser_load=0, busy=0, mux_sel=11, ser_en=0 throughout.
- Frame, no parity: PAR_EN=0, Data_Valid pulse 1 cycle.
  - mux_sel sequence 00, then 01 x8 (ser_idx 0..7, ser_en=1), then 11 with frame_done=1.
  - busy high for exactly 10 cycles, then IDLE.
- Frame, parity: PAR_EN=1 at accept, then PAR_EN=0 one cycle later -> sequence 00, 01x8, 10, 11; busy 11 cycles; parity cycle still present.
- Back-to-back: Data_Valid asserted during STOP -> ser_load=1 in the STOP cycle; the next cycle is mux_sel=00 with no idle gap; two frame_done pulses exactly 10 cycles apart.
- Ignored strobe: Data_Valid=1 at DATA cycle 3 -> ser_load=0; counter and sequence unchanged; frame completes normally.
- Abort: RST=0 at DATA cycle 5 -> next cycle IDLE, mux_sel=11, ser_idx=0, no frame_done. The next Data_Valid starts a clean 10-cycle frame.
